// File: rtl/jtframe_mixer_seq_if.sv
// Handshake/data bundle for the sequential N-channel mixer.
// The sound side drives cen/ch/gain; the mixer returns the mixed sample.
interface jtframe_mixer_seq_if #(
  parameter int CH   = 4,
  parameter int WIN  = 16,
  parameter int WOUT = 16
);
  logic              cen;
  logic [CH*WIN-1:0] ch;
  logic [CH*8-1:0]   gain;
  logic [WOUT-1:0]   mixed;
  logic              sample;
  logic              busy;
  logic              peak;
  logic              peak_clr;

  modport master (
    output cen, ch, gain, peak_clr,
    input  mixed, sample, busy, peak
  );

  modport slave (
    input  cen, ch, gain, peak_clr,
    output mixed, sample, busy, peak
  );
endinterface

// File: rtl/jtframe_mixer_seq.sv
// Time-multiplexed N-channel signed mixer, 4.4 gains, one MAC per clk.
// Optional sticky clip flag built with JTFRAME_MIXER_PEAK_EN.
module jtframe_mixer_seq #(
  parameter int CH   = 4,
  parameter int WIN  = 16,
  parameter int WOUT = 16
) (
  input  logic clk,
  input  logic rst,
  jtframe_mixer_seq_if.slave bus
);
  localparam int IW = $clog2(CH);
  localparam int AW = WIN + 9 + IW;
  localparam int SH = 4 + WIN - WOUT;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] SAT  = 2'd3;

  logic [1:0]           r_st;
  logic [IW-1:0]        r_idx;
  logic [CH*WIN-1:0]    r_ch;
  logic [CH*8-1:0]      r_gain;
  logic signed [AW-1:0] r_acc;
  logic [WOUT-1:0]      r_mixed;
  logic                 r_sample;
  logic                 r_busy;
  logic                 r_peak;

  logic signed [WIN-1:0] w_x;
  logic [7:0]            w_g;
  logic signed [WIN+8:0] w_prod;
  logic signed [AW-1:0]  w_prodx;
  logic signed [AW-1:0]  w_r;
  logic                  w_ovf;
  logic [WOUT-1:0]       w_sat;

  assign w_x     = r_ch[r_idx*WIN +: WIN];
  assign w_g     = r_gain[r_idx*8 +: 8];
  assign w_prod  = w_x * $signed({1'b0, w_g});
  assign w_prodx = {{IW{w_prod[WIN+8]}}, w_prod};
  assign w_r     = r_acc >>> SH;

  // in range only when all bits above the output MSB match the sign
  assign w_ovf = !((&w_r[AW-1:WOUT-1]) | ~(|w_r[AW-1:WOUT-1]));
  assign w_sat = w_ovf ? {w_r[AW-1], {(WOUT-1){~w_r[AW-1]}}}
                       : w_r[WOUT-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st     <= IDLE;
      r_idx    <= '0;
      r_ch     <= '0;
      r_gain   <= '0;
      r_acc    <= '0;
      r_mixed  <= '0;
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      unique case (r_st)
        IDLE: if (bus.cen) begin
          r_ch   <= bus.ch;
          r_gain <= bus.gain;
          r_acc  <= '0;
          r_busy <= 1'b1;
          r_st   <= LOAD;
        end
        LOAD: begin
          r_idx <= '0;
          r_st  <= ACC;
        end
        ACC: begin
          r_acc <= r_acc + w_prodx;
          r_idx <= r_idx + IW'(1);
          if (r_idx == IW'(CH-1)) r_st <= SAT;
        end
        SAT: begin
          r_mixed  <= w_sat;
          r_sample <= 1'b1;
          r_busy   <= 1'b0;
          r_st     <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
  end

`ifdef JTFRAME_MIXER_PEAK_EN
  // a clip on the SAT clk beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)
      r_peak <= 1'b0;
    else if (r_st == SAT && w_ovf)
      r_peak <= 1'b1;
    else if (bus.peak_clr)
      r_peak <= 1'b0;
  end
`else
  logic w_unused;
  assign w_unused = bus.peak_clr;
  assign r_peak   = 1'b0;
`endif

  assign bus.mixed  = r_mixed;
  assign bus.sample = r_sample;
  assign bus.busy   = r_busy;
  assign bus.peak   = r_peak;
endmodule
